// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and fetch FSM states.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 10;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] OPC_ADD   = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_SUB   = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_AND   = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_OR    = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_XOR   = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_NOT   = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_SHL   = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_SHR   = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_LDI   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_MOV   = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: control-unit jump input, instruction-memory port and downstream handshake.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic               load_PC;
  logic [PC_W-1:0]    pc_value;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc_out;
  logic               halted;

  modport master (
    input  load_PC, pc_value, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instruction, instr_valid, pc_out, halted
  );

  modport slave (
    output load_PC, pc_value, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instruction, instr_valid, pc_out, halted
  );

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter register: load beats increment, increment wraps at 2^WIDTH.
module pc_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (load)
      pc_next = load_value;
    else if (inc)
      pc_next = pc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_VAL;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues instruction-memory reads from the PC and hands words to the control unit.
//   state  | meaning
//   IDLE   | first cycle after reset
//   REQ    | read strobe on imem_req for this cycle
//   WAIT   | awaiting imem_rvalid (drop=1 marks the response stale)
//   HOLD   | word on instruction until instr_ready
//   HALTED | HALT opcode fetched; only load_PC or reset restarts
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [OPC_W-1:0] HALT_OPCODE = OPC_HALT
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t       state, state_nxt;
  logic               drop, drop_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic               resp, resp_live, is_halt, pc_inc;

  logic               imem_req_q;
  logic [PC_W-1:0]    imem_addr_q;
  logic [INSTR_W-1:0] instruction_q;
  logic               instr_valid_q;
  logic [PC_W-1:0]    pc_out_q;
  logic               halted_q;

  assign resp      = (state == WAIT) && bus.imem_rvalid;
  assign is_halt   = (bus.imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPCODE);
  assign resp_live = resp && !drop && !bus.load_PC;
  assign pc_inc    = resp_live && !is_halt;

  pc_counter #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (reset),
    .load       (bus.load_PC),
    .load_value (bus.pc_value),
    .inc        (pc_inc),
    .pc         (pc),
    .pc_next    (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (bus.load_PC) begin
      case (state)
        IDLE, HALTED: state_nxt = REQ;
        REQ:          state_nxt = WAIT;
        WAIT:         state_nxt = bus.imem_rvalid ? REQ : WAIT;
        HOLD:         state_nxt = REQ;
        default:      state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     state_nxt = WAIT;
        WAIT:    if (bus.imem_rvalid) state_nxt = drop ? REQ : (is_halt ? HALTED : HOLD);
        HOLD:    if (bus.instr_ready) state_nxt = REQ;
        HALTED:  state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A request already issued for the old PC must have its response discarded.
  always_comb begin
    drop_nxt = drop;
    if (resp)
      drop_nxt = 1'b0;
    if (bus.load_PC && ((state == REQ) || ((state == WAIT) && !bus.imem_rvalid)))
      drop_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      drop          <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
      halted_q      <= 1'b0;
    end else begin
      state         <= state_nxt;
      drop          <= drop_nxt;
      imem_req_q    <= (state_nxt == REQ);
      if (state_nxt == REQ)
        imem_addr_q <= pc_nxt;
      if (pc_inc) begin
        instruction_q <= bus.imem_rdata;
        pc_out_q      <= pc;
      end
      instr_valid_q <= (state_nxt == HOLD);
      halted_q      <= (state_nxt == HALTED);
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instruction = instruction_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency instruction-memory model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int valid_seen = 0;

  logic [INSTR_W-1:0] mem [0:255];
  int                 mem_lat = 1;
  int                 mem_cnt = 0;
  logic [PC_W-1:0]    mem_addr;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.instr_valid === 1'b1)
      valid_seen = valid_seen + 1;
  end

  // Memory: response appears mem_lat cycles after the request cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_cnt = 0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      bus.imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem[mem_addr];
        end
      end
      if (bus.imem_req === 1'b1) begin
        mem_cnt  = mem_lat;
        mem_addr = bus.imem_addr;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.load_PC  = 1'b0;
    bus.pc_value = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_req(output logic [PC_W-1:0] addr, output bit ok);
    ok = 1'b0;
    addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        addr = bus.imem_addr;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int at_cyc, output bit ok);
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [PC_W-1:0] a;
    bit ok;
    reset = 1'b1;
    bus.load_PC = 1'b0;
    bus.pc_value = '0;
    bus.instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.imem_addr); else passed++;
    total++; if (bus.instruction !== 10'h000) $display("FAIL rst_instr: got %h want 000", bus.instruction); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.instr_valid); else passed++;
    total++; if (bus.pc_out !== 8'h00) $display("FAIL rst_pc_out: got %h want 00", bus.pc_out); else passed++;
    total++; if (bus.halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", bus.halted); else passed++;
    reset = 1'b0;
    wait_req(a, ok);
    total++; if (!ok || a !== 8'h00) $display("FAIL first_req: got ok=%0d addr %h want addr 00", ok, a); else passed++;
  endtask

  task automatic test_sequential();
    logic [PC_W-1:0] a;
    bit ok;
    int c, c_prev;
    logic [INSTR_W-1:0] exp_w [0:2];
    exp_w[0] = 10'h000; exp_w[1] = 10'h0C1; exp_w[2] = 10'h2D5;
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    do_reset();
    c_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(a, ok);
      total++; if (!ok || a !== PC_W'(k)) $display("FAIL seq_addr%0d: got ok=%0d addr %h want %h", k, ok, a, k); else passed++;
      wait_valid(c, ok);
      total++; if (!ok || bus.instruction !== exp_w[k]) $display("FAIL seq_instr%0d: got ok=%0d %h want %h", k, ok, bus.instruction, exp_w[k]); else passed++;
      total++; if (bus.pc_out !== PC_W'(k)) $display("FAIL seq_pc_out%0d: got %h want %h", k, bus.pc_out, k); else passed++;
      if (k > 0) begin
        total++; if (c - c_prev !== 3) $display("FAIL seq_rate%0d: got %0d cycles want 3", k, c - c_prev); else passed++;
      end
      c_prev = c;
    end
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] a;
    bit ok;
    int c;
    mem[0] = 10'h155;
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(c, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (!ok || bus.instruction !== 10'h155 || bus.pc_out !== 8'h00 || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0)
        $display("FAIL stall_hold%0d: got instr %h pc_out %h valid %b req %b want 155 00 1 0",
                 i, bus.instruction, bus.pc_out, bus.instr_valid, bus.imem_req);
      else passed++;
    end
    bus.instr_ready = 1'b1;
    wait_req(a, ok);
    total++; if (!ok || a !== 8'h01) $display("FAIL stall_next_addr: got ok=%0d addr %h want 01", ok, a); else passed++;
    mem[0] = 10'h000;
  endtask

  task automatic test_jump_drop();
    logic [PC_W-1:0] a;
    bit ok;
    int c, v0;
    mem[0] = 10'h2AA;
    mem[8'h20] = 10'h123;
    mem_lat = 3;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_req(a, ok);
    v0 = valid_seen;
    repeat (2) @(negedge clk);
    bus.load_PC = 1'b1;
    bus.pc_value = 8'h20;
    @(negedge clk);
    bus.load_PC = 1'b0;
    wait_req(a, ok);
    total++; if (!ok || a !== 8'h20) $display("FAIL jump_addr: got ok=%0d addr %h want 20", ok, a); else passed++;
    total++; if (valid_seen !== v0) $display("FAIL jump_no_stale: got %0d valid cycles want %0d", valid_seen, v0); else passed++;
    wait_valid(c, ok);
    total++; if (!ok || bus.instruction !== 10'h123) $display("FAIL jump_instr: got ok=%0d %h want 123", ok, bus.instruction); else passed++;
    total++; if (bus.pc_out !== 8'h20) $display("FAIL jump_pc_out: got %h want 20", bus.pc_out); else passed++;
    mem[0] = 10'h000;
  endtask

  task automatic test_load_with_rvalid();
    logic [PC_W-1:0] a;
    bit ok;
    int c, v0;
    mem[0] = 10'h2AA;
    mem[8'h40] = 10'h0F0;
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_req(a, ok);
    v0 = valid_seen;
    @(negedge clk);
    total++; if (bus.imem_rvalid !== 1'b1) $display("FAIL coin_rvalid: got %b want 1", bus.imem_rvalid); else passed++;
    bus.load_PC = 1'b1;
    bus.pc_value = 8'h40;
    @(negedge clk);
    bus.load_PC = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) $display("FAIL coin_req: got req %b addr %h want 1 40", bus.imem_req, bus.imem_addr); else passed++;
    total++; if (bus.instr_valid !== 1'b0 || valid_seen !== v0) $display("FAIL coin_no_old: got valid %b seen %0d want 0 %0d", bus.instr_valid, valid_seen, v0); else passed++;
    wait_valid(c, ok);
    total++; if (!ok || bus.instruction !== 10'h0F0) $display("FAIL coin_instr: got ok=%0d %h want 0f0", ok, bus.instruction); else passed++;
    total++; if (bus.pc_out !== 8'h40) $display("FAIL coin_pc_out: got %h want 40", bus.pc_out); else passed++;
    mem[0] = 10'h000;
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] a;
    bit ok;
    int c;
    mem[8'hFF] = 10'h1A5;
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(c, ok);
    bus.load_PC = 1'b1;
    bus.pc_value = 8'hFF;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.load_PC = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'hFF)
      $display("FAIL hold_discard: got valid %b req %b addr %h want 0 1 ff", bus.instr_valid, bus.imem_req, bus.imem_addr);
    else passed++;
    wait_valid(c, ok);
    total++; if (!ok || bus.instruction !== 10'h1A5) $display("FAIL wrap_instr: got ok=%0d %h want 1a5", ok, bus.instruction); else passed++;
    total++; if (bus.pc_out !== 8'hFF) $display("FAIL wrap_pc_out: got %h want ff", bus.pc_out); else passed++;
    wait_req(a, ok);
    total++; if (!ok || a !== 8'h00) $display("FAIL wrap_addr: got ok=%0d addr %h want 00", ok, a); else passed++;
  endtask

  task automatic test_halt_and_reset();
    logic [PC_W-1:0] a;
    bit ok;
    int v0, reqs;
    mem[0] = 10'h3C0;
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_req(a, ok);
    v0 = valid_seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.halted === 1'b1) break;
    end
    total++; if (bus.halted !== 1'b1) $display("FAIL halt_flag: got %b want 1", bus.halted); else passed++;
    total++; if (bus.instr_valid !== 1'b0 || valid_seen !== v0) $display("FAIL halt_no_valid: got valid %b seen %0d want 0 %0d", bus.instr_valid, valid_seen, v0); else passed++;
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) reqs++;
    end
    total++; if (reqs !== 0 || bus.halted !== 1'b1) $display("FAIL halt_idle: got %0d reqs halted %b want 0 1", reqs, bus.halted); else passed++;
    mem_lat = 3;
    bus.load_PC = 1'b1;
    bus.pc_value = 8'h05;
    @(negedge clk);
    bus.load_PC = 1'b0;
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_exit: got halted %b want 0", bus.halted); else passed++;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h05) $display("FAIL halt_restart_req: got req %b addr %h want 1 05", bus.imem_req, bus.imem_addr); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00 || bus.instruction !== 10'h000)
      $display("FAIL async_rst_bus: got req %b addr %h instr %h want 0 00 000", bus.imem_req, bus.imem_addr, bus.instruction);
    else passed++;
    total++; if (bus.instr_valid !== 1'b0 || bus.pc_out !== 8'h00 || bus.halted !== 1'b0)
      $display("FAIL async_rst_flags: got valid %b pc_out %h halted %b want 0 00 0", bus.instr_valid, bus.pc_out, bus.halted);
    else passed++;
    mem[0] = 10'h000;
    mem_lat = 1;
    @(negedge clk);
    reset = 1'b0;
    wait_req(a, ok);
    total++; if (!ok || a !== 8'h00) $display("FAIL rst_restart_addr: got ok=%0d addr %h want 00", ok, a); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 10'h001;
    mem[0] = 10'h000;
    mem[1] = 10'h0C1;
    mem[2] = 10'h2D5;
    test_reset();
    test_sequential();
    test_stall();
    test_jump_drop();
    test_load_with_rvalid();
    test_wrap();
    test_halt_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
